// File: rtl/shift_pkg.sv
// Shared constants for the shift register family and its load sequencer.
// State encoding and default widths.
package shift_pkg;

    localparam int SHIFT_WIDTH = 4;
    localparam int SHIFT_DIV_W = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/shift_load_ctrl_if.sv
// Word-offer handshake between a producer and the load sequencer.
// The producer is master; the sequencer is slave.
interface shift_load_ctrl_if
    import shift_pkg::*;
#(
    parameter int WIDTH = SHIFT_WIDTH,
    parameter int DIV_W = SHIFT_DIV_W
);

    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] word;
    logic [DIV_W-1:0] div;

    modport master (
        output start_valid,
        output word,
        output div,
        input  start_ready
    );

    modport slave (
        input  start_valid,
        input  word,
        input  div,
        output start_ready
    );

endinterface

// File: rtl/shift_rate_counter.sv
// Loadable down-counter pacing the shifts.
// zero marks the cycle a shift may happen.
module shift_rate_counter
    import shift_pkg::*;
#(
    parameter int DIV_W = SHIFT_DIV_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             dec,
    input  logic [DIV_W-1:0] load_val,
    output logic             zero
);

    logic [DIV_W-1:0] cnt;

    // Reload takes precedence; otherwise count down toward zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/shift_load_ctrl.sv
// Feeds a parallel word LSB-first into a right-shift register,
// then reports the register contents once all bits are in.
module shift_load_ctrl
    import shift_pkg::*;
#(
    parameter int WIDTH = SHIFT_WIDTH,
    parameter int DIV_W = SHIFT_DIV_W
) (
    input  logic             clk,
    input  logic             rst,
    shift_load_ctrl_if.slave s,
    input  logic             abort,
    output logic             sh_enable,
    output logic             sh_din,
    input  logic [WIDTH-1:0] q_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] data_out
);

    localparam int BW = $clog2(WIDTH) + 1;
    localparam logic [BW-1:0] LAST = BW'(WIDTH - 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] sreg;
    logic [DIV_W-1:0] div_r;
    logic [BW-1:0]    bits;
    logic             zero;
    logic             accept;
    logic             in_run;
    logic             shift;

    assign s.start_ready = (state == ST_IDLE);
    assign accept        = s.start_valid & s.start_ready;
    assign in_run        = (state == ST_RUN);
    assign shift         = in_run & zero & ~abort;
    assign sh_enable     = shift;
    assign sh_din        = shift & sreg[0];
    assign busy          = in_run | (state == ST_DONE);

    shift_rate_counter #(
        .DIV_W (DIV_W)
    ) u_rate (
        .clk      (clk),
        .rst      (rst),
        .load     (accept | shift),
        .dec      (in_run & ~zero & ~abort),
        .load_val (accept ? s.div : div_r),
        .zero     (zero)
    );

    // Control flow: IDLE -> RUN -> DONE -> IDLE, abort drops RUN to IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (accept) state <= ST_RUN;
                ST_RUN: begin
                    if (abort) state <= ST_IDLE;
                    else if (shift && bits == LAST) state <= ST_DONE;
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Word shadow, rate and bit count: loaded on accept, stepped per shift.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sreg  <= '0;
            div_r <= '0;
            bits  <= '0;
        end else if (accept) begin
            sreg  <= s.word;
            div_r <= s.div;
            bits  <= '0;
        end else if (shift) begin
            sreg  <= sreg >> 1;
            bits  <= bits + 1'b1;
        end
    end

    // Completion: capture the register readback as DONE ends.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done     <= 1'b0;
            data_out <= '0;
        end else begin
            done <= (state == ST_DONE);
            if (state == ST_DONE) data_out <= q_in;
        end
    end

endmodule

// File: tb/tb_shift_load_ctrl.sv
// Bench for shift_load_ctrl driving a 4-bit right-shift register.
// Schedule-based model checked every cycle plus directed literal checks.
module tb_shift_load_ctrl;

    localparam int W = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       abort = 1'b0;
    logic       sh_enable, sh_din, busy, done;
    logic [3:0] q_in, data_out;

    shift_load_ctrl_if #(.WIDTH(4), .DIV_W(8)) bus ();

    shift_load_ctrl #(.WIDTH(4), .DIV_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .s         (bus),
        .abort     (abort),
        .sh_enable (sh_enable),
        .sh_din    (sh_din),
        .q_in      (q_in),
        .busy      (busy),
        .done      (done),
        .data_out  (data_out)
    );

    always #5 clk = ~clk;

    // Controlled register: din enters the MSB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) q_in <= '0;
        else if (sh_enable) q_in <= {sh_din, q_in[3:1]};
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     name, got, exp, $time);
        end
    endtask

    // Model: a load accepted in cycle k with rate d shifts bit i of the word
    // in cycle k+1+d+i*(d+1), sits in DONE one cycle, reports the next.
    bit         act = 0;
    int         k = 0, d = 0, cyc = 0, done_cyc = -1;
    logic [3:0] w = '0, m_dout = '0;

    function automatic void model_out(input int c, input logic ab,
        output logic e_rdy, output logic e_busy, output logic e_en,
        output logic e_din, output logic e_done, output logic [3:0] e_dout);
        int t, per, off;
        e_busy = 0; e_en = 0; e_din = 0;
        if (act) begin
            t = c - k;
            per = d + 1;
            if (t >= 1 && t <= W * per + 1) e_busy = 1;
            if (t >= 1 && t <= W * per && !ab) begin
                off = t - 1 - d;
                if (off >= 0 && off % per == 0) begin
                    e_en = 1;
                    e_din = w[off / per];
                end
            end
        end
        e_rdy = !e_busy;
        e_done = (c == done_cyc);
        e_dout = m_dout;
    endfunction

    initial forever begin
        logic r, b, e, dn, dd;
        logic [3:0] dq;
        int t;
        @(posedge clk or posedge rst);
        if (rst) begin
            act = 0; done_cyc = -1; m_dout = '0;
        end else begin
            model_out(cyc, abort, r, b, e, dn, dd, dq);
            t = cyc - k;
            if (act && b && t <= W * (d + 1) && abort) begin
                act = 0;
            end else if (act && t == W * (d + 1) + 1) begin
                done_cyc = cyc + 1; m_dout = w; act = 0;
            end
            if (r && bus.start_valid) begin
                act = 1; k = cyc; d = int'(bus.div); w = bus.word;
            end
            cyc++;
        end
    end

    bit chk_en = 0;

    initial forever begin
        logic r, b, e, dn, dd;
        logic [3:0] dq;
        @(negedge clk);
        if (chk_en) begin
            model_out(cyc, abort, r, b, e, dn, dd, dq);
            check("m_start_ready", bus.start_ready, r);
            check("m_busy", busy, b);
            check("m_sh_enable", sh_enable, e);
            check("m_sh_din", sh_din, dn);
            check("m_done", done, dd);
            check("m_data_out", data_out, dq);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    logic [3:0]  rec_dout [0:31];
    logic [31:0] ev, dv, nv;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic watch(input int n, input int drop,
        output logic [31:0] e_v, output logic [31:0] d_v,
        output logic [31:0] n_v);
        e_v = '0; d_v = '0; n_v = '0;
        for (int i = 0; i < n; i++) begin
            if (i == drop) bus.start_valid = 1'b0;
            e_v[i] = sh_enable;
            d_v[i] = sh_din;
            n_v[i] = done;
            rec_dout[i] = data_out;
            tick();
        end
    endtask

    task automatic offer(input logic [3:0] wd, input logic [7:0] dv_in);
        bus.start_valid = 1'b1;
        bus.word = wd;
        bus.div = dv_in;
        tick();
    endtask

    initial begin
        bus.start_valid = 1'b0;
        bus.word = '0;
        bus.div = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk_en = 1;
        check("rst_ready", bus.start_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_en", sh_enable, 0);
        check("rst_din", sh_din, 0);
        check("rst_done", done, 0);
        check("rst_dout", data_out, 0);
        tick();

        // div=0, word 1011
        offer(4'b1011, 8'd0);
        bus.start_valid = 1'b0;
        watch(6, -1, ev, dv, nv);
        check("t1_en", ev, 32'h0F);
        check("t1_din", dv, 32'h0B);
        check("t1_done", nv, 32'h20);
        check("t1_dout", rec_dout[5], 4'hB);
        tick(); tick();

        // div=2, word 0110
        offer(4'b0110, 8'd2);
        bus.start_valid = 1'b0;
        watch(14, -1, ev, dv, nv);
        check("t2_en", ev, 32'h924);
        check("t2_din", dv, 32'h120);
        check("t2_done", nv, 32'h2000);
        check("t2_dout", rec_dout[13], 4'h6);

        // abort on the 2nd shift
        offer(4'b0101, 8'd0);
        bus.start_valid = 1'b0;
        tick();
        abort = 1'b1;
        #1;
        check("t3_abort_en", sh_enable, 0);
        check("t3_abort_busy", busy, 1);
        tick();
        abort = 1'b0;
        check("t3_idle_ready", bus.start_ready, 1);
        check("t3_idle_busy", busy, 0);
        watch(5, -1, ev, dv, nv);
        check("t3_no_done", nv, 32'h0);
        check("t3_dout_kept", rec_dout[4], 4'h6);
        offer(4'b1111, 8'd0);
        bus.start_valid = 1'b0;
        watch(6, -1, ev, dv, nv);
        check("t3b_en", ev, 32'h0F);
        check("t3b_din", dv, 32'h0F);
        check("t3b_done", nv, 32'h20);
        check("t3b_dout", rec_dout[5], 4'hF);

        // back-to-back, valid held through RUN
        offer(4'b0001, 8'd0);
        bus.word = 4'b1000;
        watch(12, 11, ev, dv, nv);
        check("t4_en", ev, 32'h3CF);
        check("t4_din", dv, 32'h201);
        check("t4_done", nv, 32'h820);
        check("t4_dout1", rec_dout[5], 4'h1);
        check("t4_dout2", rec_dout[11], 4'h8);

        // reset mid-RUN, div=3
        tick();
        offer(4'b0011, 8'd3);
        bus.start_valid = 1'b0;
        tick(); tick(); tick();
        check("t5_pre_en", sh_enable, 1);
        #2 rst = 1'b1;
        #1;
        check("t5_rst_busy", busy, 0);
        check("t5_rst_ready", bus.start_ready, 1);
        check("t5_rst_en", sh_enable, 0);
        check("t5_rst_din", sh_din, 0);
        check("t5_rst_done", done, 0);
        check("t5_rst_dout", data_out, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        tick();
        offer(4'b1001, 8'd3);
        bus.start_valid = 1'b0;
        watch(18, -1, ev, dv, nv);
        check("t5_en", ev, 32'h8888);
        check("t5_din", dv, 32'h8008);
        check("t5_done", nv, 32'h20000);
        check("t5_dout", rec_dout[17], 4'h9);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
